// File: rtl/expr_pkg.sv
// Shared definitions for the expression serializer.
// - Token codes as they appear on tok_kind.
// - ASCII constants for the characters the serializer can emit.
// - Grammar state encoding.
// - Small token/decode structs and a digit-to-ASCII helper.
package expr_pkg;

  // Token codes (3-bit tok_kind); 6 and 7 are unassigned and always illegal.
  localparam logic [2:0] TK_NUM  = 3'd0;
  localparam logic [2:0] TK_ADD  = 3'd1;
  localparam logic [2:0] TK_MUL  = 3'd2;
  localparam logic [2:0] TK_LPAR = 3'd3;
  localparam logic [2:0] TK_RPAR = 3'd4;
  localparam logic [2:0] TK_END  = 3'd5;

  // ASCII characters.
  localparam logic [7:0] ASC_LPAR = 8'h28;
  localparam logic [7:0] ASC_RPAR = 8'h29;
  localparam logic [7:0] ASC_MUL  = 8'h2A;
  localparam logic [7:0] ASC_ADD  = 8'h2B;
  localparam logic [7:0] ASC_0    = 8'h30;

  // Grammar states: expecting an operand or an operator, at top level or
  // inside a parenthesised group.
  typedef enum logic [1:0] {
    OPND_TOP = 2'd0,
    OP_TOP   = 2'd1,
    OPND_IN  = 2'd2,
    OP_IN    = 2'd3
  } gstate_e;

  // Incoming token as a single bundle.
  typedef struct packed {
    logic [2:0] kind;
    logic [6:0] val;
  } tok_t;

  // Per-token decode result: what the token does to the grammar and what
  // it puts on the character stream.
  typedef struct packed {
    logic       legal;  // token is allowed in the current state
    logic       fin;    // legal END: closes the expression
    logic       emit;   // token produces at least one character
    logic       split;  // a units digit follows the first character
    logic [7:0] first;  // first character emitted
  } dec_t;

  // Decimal digit 0..9 to its ASCII character.
  function automatic logic [7:0] digit_ch(input logic [3:0] d);
    return ASC_0 + {4'd0, d};
  endfunction

endpackage

// File: rtl/expr_tx_num_split.sv
// num_split: combinational split of a 7-bit operand into decimal digits.
// Ports:
//   val       in  7  operand value (0..127)
//   tens      out 4  val / 10
//   units     out 4  val % 10
//   two_digit out 1  val >= 10, i.e. a tens digit must be emitted
// Values above 99 produce tens > 9; the caller rejects those before use.
module num_split (
  input  logic [6:0] val,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic       two_digit
);

  always_comb begin
    tens      = 4'(val / 7'd10);
    units     = 4'(val - 7'(tens) * 7'd10);
    two_digit = (val >= 7'd10);
  end

endmodule

// File: rtl/expr_tx.sv
// expr_tx: serializes a token stream into an ASCII arithmetic expression.
// Grammar: operand (op operand)*, operand = number | "(" number (op number)* ")".
// Illegal tokens are consumed silently except for a one-cycle err pulse and
// leave the grammar state untouched; a legal END pulses done.
// Ports:
//   clk        in   1  clock, posedge
//   clr        in   1  asynchronous active-high reset
//   tok_valid  in   1  token offered
//   tok_ready  out  1  token accepted on posedge when tok_valid && tok_ready
//   tok_kind   in   3  token code (see expr_pkg)
//   tok_val    in   7  operand value for NUM
//   ch         out  8  ASCII character
//   ch_valid   out  1  ch holds a character
//   ch_ready   in   1  character consumed on posedge when ch_valid && ch_ready
//   err        out  1  pulse after an illegal token is accepted
//   done       out  1  pulse after a legal END is accepted
module expr_tx
  import expr_pkg::*;
#(
  parameter int NUM_MAX = 99
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       tok_valid,
  output logic       tok_ready,
  input  logic [2:0] tok_kind,
  input  logic [6:0] tok_val,
  output logic [7:0] ch,
  output logic       ch_valid,
  input  logic       ch_ready,
  output logic       err,
  output logic       done
);

  localparam logic [6:0] MAX_V = 7'(NUM_MAX);

  tok_t       tok;
  dec_t       dec;
  gstate_e    st, st_nxt;
  logic       pend;       // units digit waiting behind the tens digit
  logic [3:0] units_q;
  logic [3:0] tens, units;
  logic       two_digit;
  logic       num_ok, is_op;
  logic       accept, consume;

  assign tok = {tok_kind, tok_val};

  num_split u_split (
    .val       (tok.val),
    .tens      (tens),
    .units     (units),
    .two_digit (two_digit)
  );

  assign num_ok  = (tok.kind == TK_NUM) && (tok.val <= MAX_V);
  assign is_op   = (tok.kind == TK_ADD) || (tok.kind == TK_MUL);
  assign accept  = tok_valid && tok_ready;
  assign consume = ch_valid && ch_ready;

  // State register. Illegal tokens leave st_nxt == st.
  always_ff @(posedge clk or posedge clr) begin
    if (clr)         st <= OPND_TOP;
    else if (accept) st <= st_nxt;
  end

  // Next-state: legality of the offered token in the current state.
  always_comb begin
    st_nxt    = st;
    dec.legal = 1'b0;
    dec.fin   = 1'b0;
    case (st)
      OPND_TOP: begin
        if (num_ok) begin
          dec.legal = 1'b1;
          st_nxt    = OP_TOP;
        end else if (tok.kind == TK_LPAR) begin
          dec.legal = 1'b1;
          st_nxt    = OPND_IN;
        end
      end
      OP_TOP: begin
        if (is_op) begin
          dec.legal = 1'b1;
          st_nxt    = OPND_TOP;
        end else if (tok.kind == TK_END) begin
          dec.legal = 1'b1;
          dec.fin   = 1'b1;
          st_nxt    = OPND_TOP;
        end
      end
      OPND_IN: begin
        if (num_ok) begin
          dec.legal = 1'b1;
          st_nxt    = OP_IN;
        end
      end
      OP_IN: begin
        if (is_op) begin
          dec.legal = 1'b1;
          st_nxt    = OPND_IN;
        end else if (tok.kind == TK_RPAR) begin
          dec.legal = 1'b1;
          st_nxt    = OP_TOP;
        end
      end
      default: ;
    endcase
  end

  // Outputs: handshake and the character(s) a legal token produces.
  // A pending units digit blocks new tokens so it always follows its tens
  // digit directly.
  always_comb begin
    tok_ready = (!ch_valid || ch_ready) && !pend;
    dec.emit  = dec.legal && (tok.kind != TK_END);
    dec.split = 1'b0;
    dec.first = ASC_0;
    case (tok.kind)
      TK_NUM: begin
        dec.first = two_digit ? digit_ch(tens) : digit_ch(units);
        dec.split = two_digit;
      end
      TK_ADD:  dec.first = ASC_ADD;
      TK_MUL:  dec.first = ASC_MUL;
      TK_LPAR: dec.first = ASC_LPAR;
      TK_RPAR: dec.first = ASC_RPAR;
      default: ;
    endcase
  end

  // Character register and event pulses.
  // accept implies !pend, so the three load cases below never overlap.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      ch       <= 8'h00;
      ch_valid <= 1'b0;
      pend     <= 1'b0;
      units_q  <= 4'd0;
      err      <= 1'b0;
      done     <= 1'b0;
    end else begin
      err  <= accept && !dec.legal;
      done <= accept && dec.fin;
      if (pend && consume) begin
        // Tens digit leaves, units digit takes its place; ch_valid stays high.
        ch   <= digit_ch(units_q);
        pend <= 1'b0;
      end else if (accept && dec.emit) begin
        ch       <= dec.first;
        ch_valid <= 1'b1;
        pend     <= dec.split;
        units_q  <= units;
      end else if (consume) begin
        ch_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/expr_tx.md
EXPR_TX -- requirements
Module: expr_tx

Interface
REQ-001 SHALL have parameter NUM_MAX, default 99, the largest legal operand value; legal range 9..99.
REQ-002 SHALL have port clk  input  1  clock; all state updates on posedge.
REQ-003 SHALL have port clr  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port tok_valid  input  1  token offered.
REQ-005 SHALL have port tok_ready  output  1  token accepted on posedge when tok_valid&&tok_ready.
REQ-006 SHALL have port tok_kind  input  3  token code: 0 NUM, 1 ADD, 2 MUL, 3 LPAR, 4 RPAR, 5 END; 6-7 illegal.
REQ-007 SHALL have port tok_val  input  7  operand value, used only for NUM.
REQ-008 SHALL have port ch  output  8  ASCII character out.
REQ-009 SHALL have port ch_valid  output  1  ch holds a character.
REQ-010 SHALL have port ch_ready  input  1  character consumed on posedge when ch_valid&&ch_ready.
REQ-011 SHALL have port err  output  1  one-cycle pulse on acceptance of an illegal token.
REQ-012 SHALL have port done  output  1  one-cycle pulse on acceptance of a legal END.

Function
REQ-013 SHALL serialize accepted tokens into the ASCII expression grammar: operand (op operand)*, where an operand is a number or "(" number (op number)* ")". Nesting is illegal.
REQ-014 SHALL encode characters as follows: ADD 0x2B '+', MUL 0x2A '*', LPAR 0x28, RPAR 0x29. NUM values 0..9 SHALL be emitted as one digit (0x30+v). NUM values 10..NUM_MAX SHALL be emitted as a tens digit followed by a units digit; no leading zero is ever emitted.
REQ-015 SHALL use grammar states OPND_TOP (reset), OP_TOP, OPND_IN, OP_IN.
REQ-016 SHALL apply these legal transitions:
- OPND_TOP: NUM -> OP_TOP; LPAR -> OPND_IN.
- OP_TOP: ADD/MUL -> OPND_TOP; END -> OPND_TOP with done pulse.
- OPND_IN: NUM -> OP_IN.
- OP_IN: ADD/MUL -> OPND_IN; RPAR -> OP_TOP.
REQ-017 SHALL treat every other token as illegal. An illegal token is any token not listed in REQ-016, NUM with tok_val>NUM_MAX, or kind 6-7. An illegal token SHALL be accepted (consumed), SHALL pulse err in the following cycle, SHALL emit no character, and SHALL leave the grammar state unchanged.
REQ-018 SHALL emit no character for END.
REQ-019 SHALL present the first character of an accepted token with ch_valid=1 on the cycle after acceptance (latency 1).
REQ-020 SHALL drive tok_ready=1 iff (ch_valid==0 or ch_ready==1) and no units digit is pending; tok_ready is combinational.
REQ-021 SHALL, for two-digit NUM, load the units digit into ch on the same edge the tens digit is consumed, keeping ch_valid high (one character per cycle at ch_ready=1).
REQ-022 SHALL hold ch and ch_valid stable while ch_valid=1 and ch_ready=0.
REQ-023 SHALL clear ch_valid on consumption when no new character is loaded on that edge.
REQ-024 SHALL keep err and done mutually exclusive, each high for exactly one cycle per event.

Reset
REQ-025 SHALL, while clr=1, force ch=0x00, ch_valid=0, err=0, done=0, the pending units digit cleared, and grammar state OPND_TOP, independent of clk.
REQ-026 SHALL discard any in-flight character or pending digit on clr; tok_ready=1 on the first cycle after clr deasserts.

Structure
REQ-027 SHALL take token codes, ASCII constants (0x28, 0x29, 0x2A, 0x2B, 0x30), and grammar state encodings from the shared package expr_pkg.
REQ-028 SHALL instantiate one sub-module, num_split, which is combinational and converts a 7-bit value to a tens digit, a units digit, and a two_digit flag.

Verification
REQ-029 SHALL cover: NUM 7, ADD, NUM 42, END at ch_ready=1 -> ch 0x37, 0x2B, 0x34, 0x32 on consecutive cycles; done pulse once; err never high.
REQ-030 SHALL cover: LPAR, NUM 0, MUL, NUM 99, RPAR, MUL, NUM 5, END -> "(0*99)*5" (0x28 0x30 0x2A 0x39 0x39 0x29 0x2A 0x35); done=1 once.
REQ-031 SHALL cover each of the following in turn: ADD first, NUM 100, LPAR inside a paren, RPAR directly after LPAR, kind 7 -> each token consumed, err pulses once, no character emitted, the following legal token is serialized correctly.
REQ-032 SHALL cover: NUM 42 with ch_ready=0 for 3 cycles after acceptance -> ch holds 0x34, tok_ready=0 throughout; 0x32 follows on the cycle after ch_ready=1.
REQ-033 SHALL cover: clr pulsed while the units digit of NUM 57 is pending -> ch_valid=0 immediately; the next NUM 3 is accepted in OPND_TOP and emits 0x33.
REQ-034 SHALL cover: END accepted in OPND_TOP and in OP_IN -> err pulse, no done pulse, grammar state unchanged.
